// File: rtl/pow_mul_pkg.sv
// Shared definitions for the power/multiply unit: FSM states and default widths.
package pow_mul_pkg;

    // Operand width and result width used when the instantiator does not override them.
    localparam int W_DEFAULT  = 4;
    localparam int RW_DEFAULT = 16;

    // Controller states: waiting for operands, iterating the power, holding the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : pow_mul_pkg

// File: rtl/pow_mul_unit_mul_trunc.sv
// Combinational RW x W multiplier returning the product modulo 2^RW plus an
// overflow flag that is set when any bit above RW-1 of the exact product is set.
module mul_trunc #(
    parameter int W  = 4,
    parameter int RW = 16
) (
    input  logic [RW-1:0] a,
    input  logic [W-1:0]  b,
    output logic [RW-1:0] p,
    output logic          ovf
);

    logic [RW+W-1:0] full_prod;

    // Exact product at full width, then split into kept bits and discarded bits.
    always_comb begin
        full_prod = {{W{1'b0}}, a} * {{RW{1'b0}}, b};
        p         = full_prod[RW-1:0];
        ovf       = |full_prod[RW+W-1:RW];
    end

endmodule : mul_trunc

// File: rtl/pow_mul_unit.sv
// Power / multiply unit: returns x**y (mod 2^RW) when x==y, otherwise x*y.
// A single multiplier is shared: it forms x*y directly at accept time, and
// acc*x once per cycle while iterating the power.
module pow_mul_unit
    import pow_mul_pkg::*;
#(
    parameter int W  = W_DEFAULT,
    parameter int RW = RW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] o,
    output logic          ovf,
    output logic          pow_mode
);

    generate
        if (RW < 2*W) begin : g_rw_check
            $error("pow_mul_unit: RW must be at least 2*W");
        end
    endgenerate

    localparam logic [W-1:0]  CNT_ONE = W'(1);
    localparam logic [RW-1:0] ACC_ONE = RW'(1);

    state_t        state_reg;
    logic [RW-1:0] acc_reg;
    logic [W-1:0]  cnt_reg;
    logic [W-1:0]  x_reg;
    logic          ovf_reg;
    logic          pow_mode_reg;

    logic [RW-1:0] mul_a;
    logic [W-1:0]  mul_b;
    logic [RW-1:0] mul_p;
    logic          mul_ovf;

    // In IDLE the multiplier sees the live operands (multiply mode); otherwise acc*x.
    always_comb begin
        mul_a = acc_reg;
        mul_b = x_reg;
        if (state_reg == IDLE) begin
            mul_a = RW'(x);
            mul_b = y;
        end
    end

    mul_trunc #(
        .W  (W),
        .RW (RW)
    ) u_mul_trunc (
        .a   (mul_a),
        .b   (mul_b),
        .p   (mul_p),
        .ovf (mul_ovf)
    );

    // Controller: accept operands, iterate the power, hold the result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            x_reg        <= '0;
            ovf_reg      <= 1'b0;
            pow_mode_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        x_reg   <= x;
                        ovf_reg <= 1'b0;
                        if (x != y) begin
                            // x*y fits in 2W <= RW bits, so no overflow is possible here.
                            acc_reg      <= mul_p;
                            cnt_reg      <= '0;
                            pow_mode_reg <= 1'b0;
                            state_reg    <= DONE;
                        end else begin
                            acc_reg      <= ACC_ONE;
                            cnt_reg      <= y;
                            pow_mode_reg <= 1'b1;
                            state_reg    <= (y == '0) ? DONE : CALC;
                        end
                    end
                end
                CALC: begin
                    acc_reg <= mul_p;
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (mul_ovf) begin
                        ovf_reg <= 1'b1;
                    end
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE) && !rst;
    assign out_valid = (state_reg == DONE);
    assign o         = acc_reg;
    assign ovf       = ovf_reg;
    assign pow_mode  = pow_mode_reg;

endmodule : pow_mul_unit
